period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the divided clock produced by the clock divider stage. It is the downstream consumer of `clk_out`.
- `clk_out` enters as `sig_in`. The block counts `clk_in` cycles between consecutive rising edges (period) and from rising to falling edge (high time).
- Results are reported with a one-cycle valid strobe, a lock indication and a timeout flag.
- It is the self-check and monitor block for the divider: software or a bench compares `period` against the programmed divisor.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- SYNC_STAGES, 2, number of synchroniser flops on `sig_in`. Minimum legal value is 2.

Ports:
- clk_in  input  1  system clock; all logic runs on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable, synchronous to `clk_in`.
- sig_in  input  1  signal under measurement (divided clock); treated as asynchronous.
- period  output  CNT_W  last measured rise-to-rise interval, in `clk_in` cycles.
- high_time  output  CNT_W  high interval belonging to that same period.
- meas_valid  output  1  one-cycle pulse; `period` and `high_time` were updated this cycle.
- locked  output  1  high while the two most recent periods are equal.
- timeout  output  1  sticky flag: counter saturated with no rising edge.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - Synchroniser, edge register, counter and pending high-time register go to 0.
  - State goes to IDLE.
  - Asserting `rst` mid-measurement aborts it with no `meas_valid`.
- Input conditioning:
  - `sig_in` passes through SYNC_STAGES flops, then one previous-value flop.
  - `rise` = sync & ~prev. `fall` = ~sync & prev.
  - Edge detection lags the pin by SYNC_STAGES+1 cycles. The lag is constant, so it cancels out of all intervals.
  - `rise` and `fall` are mutually exclusive by construction.
- State machine IDLE / ARM / MEASURE:
  - IDLE: counter held at 0. `enable`=1 -> ARM.
  - ARM: wait for `rise`. On `rise`: cnt<=1, pending_high<=0, -> MEASURE.
  - MEASURE: cnt increments by 1 each cycle, so cnt = k cycles after the starting rise.
  - MEASURE, on `fall`: pending_high<=cnt.
  - MEASURE, on `rise`:
    - period<=cnt and high_time<=pending_high.
    - meas_valid=1 in the following cycle, aligned with the new output values.
    - cnt<=1, pending_high<=0, timeout<=0. Stay in MEASURE.
  - `enable`=0 in any state -> IDLE next cycle.
    - Any in-progress measurement is discarded.
    - `period`, `high_time` and `timeout` hold their values. `locked`<=0.
- Width and saturation rules:
  - cnt is CNT_W bits and never wraps.
  - When cnt = 2^CNT_W-1 and no `rise` occurs that cycle: timeout<=1, locked<=0, -> ARM, no `meas_valid`.
  - A `rise` on the same cycle cnt reaches max is a legal measurement: period = 2^CNT_W-1, no timeout.
- Lock:
  - On each measurement, compare the new period with the previous published period.
  - Equal and nonzero -> locked<=1. Different -> locked<=0.
  - The first measurement after ARM never sets `locked`; it only loads the previous-period register.
- Corner cases:
  - A 1-cycle high pulse gives high_time=1.
  - `sig_in` stuck high or stuck low never produces `meas_valid` and eventually sets `timeout`.
  - If no `fall` occurs between two rises, high_time=0. This is only reachable with sub-cycle glitches.

Test Plan:
- Reset behaviour: `rst`=1 asserted mid-measurement, asynchronously (not aligned to `clk_in`) -> all outputs 0 immediately. After release with `enable`=1 and `sig_in` toggling, the first `meas_valid` appears only after a full rise-to-rise interval.
- Divide-by-4 waveform: `sig_in` driven 2 high / 2 low `clk_in` cycles, `enable`=1 -> every 4 cycles `meas_valid` pulses with period=4, high_time=2. `locked`=1 from the second measurement onward.
- Asymmetric waveform: 3 high / 7 low -> period=10, high_time=3. Switch to 5/5 -> first new measurement period=10, high_time=5, `locked` stays 1. Switch to 4/4 -> period=8, `locked` drops for one measurement, then re-asserts.
- Timeout with CNT_W=4: `sig_in` held low after one rise -> `timeout`=1 when cnt reaches 15, no `meas_valid`. Resume a 3/3 toggle -> `timeout` clears at the first period=6 result.
- Enable gating: `enable` dropped mid-period -> no `meas_valid`, `period`/`high_time` hold, `locked`=0. On re-enable, ARM waits for a fresh rise before measuring.
- Integration with the clock divider (divisor=4, `clk_out` into `sig_in`): `period` equals the divider's output period in `clk_in` cycles, `high_time` matches its duty cycle, and `locked` asserts within 3 output periods.

Source files
------------

// File: rtl/period_meter.sv
// Rise-to-rise period and high-time meter for an asynchronous divided clock.
// Publishes each result with a one-cycle strobe, a lock flag and a sticky timeout.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_bit;
    logic                   prev;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pending_high;
    logic             have_prev;

    logic             discard;
    logic             start;
    logic             capture;
    logic             saturate;

    // Input conditioning: synchroniser chain plus one previous-value flop
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            prev    <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_bit = sync_ff[SYNC_STAGES-1];
    assign rise     = sync_bit & ~prev;
    assign fall     = ~sync_bit & prev;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable wins over everything, including a coincident rise
    always_comb begin
        state_nxt = state;
        discard   = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        saturate  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            discard   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    if (rise) begin
                        start     = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        capture = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        saturate  = 1'b1;
                        state_nxt = ARM;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            pending_high <= '0;
            have_prev    <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            meas_valid   <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (discard) begin
                cnt          <= '0;
                pending_high <= '0;
                have_prev    <= 1'b0;
                locked       <= 1'b0;
            end else if (start) begin
                cnt          <= CNT_ONE;
                pending_high <= '0;
                have_prev    <= 1'b0;
            end else if (capture) begin
                period       <= cnt;
                high_time    <= pending_high;
                meas_valid   <= 1'b1;
                timeout      <= 1'b0;
                // The first result after arming has nothing valid to compare against
                locked       <= have_prev && (cnt == period) && (cnt != '0);
                have_prev    <= 1'b1;
                cnt          <= CNT_ONE;
                pending_high <= '0;
            end else if (saturate) begin
                timeout      <= 1'b1;
                locked       <= 1'b0;
                have_prev    <= 1'b0;
                cnt          <= '0;
            end else if (state == MEASURE) begin
                cnt <= cnt + CNT_ONE;
                if (fall) begin
                    pending_high <= cnt;
                end
            end else if (state == IDLE) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed waveforms plus random high/low segments,
// checked against a segment-level model of the published measurements.
module tb_period_meter;

    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int p;
        int h;
        int lk;
    } meas_t;

    int    vectors     = 0;
    int    miscompares = 0;
    meas_t exp_q[$];
    meas_t mon_m;

    int prev_h;
    int prev_l;
    bit prev_ok   = 1'b0;
    int last_pub  = 0;
    int last_high = 0;
    bit pub_ok    = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // A rise on the pin closes the previous high/low segment as one measurement
    task automatic model_rise(input int h, input int l);
        meas_t m;
        if (prev_ok) begin
            m.p  = prev_h + prev_l;
            m.h  = prev_h;
            m.lk = (pub_ok && m.p == last_pub) ? 1 : 0;
            exp_q.push_back(m);
            last_pub  = m.p;
            last_high = m.h;
            pub_ok    = 1'b1;
        end
        prev_h  = h;
        prev_l  = l;
        prev_ok = 1'b1;
    endtask

    task automatic model_break();
        prev_ok = 1'b0;
        pub_ok  = 1'b0;
    endtask

    task automatic drive(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic seg(input int h, input int l);
        model_rise(h, l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    always @(negedge clk_in) begin
        if (!rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_m = exp_q.pop_front();
                check("period", int'(period), mon_m.p);
                check("high_time", int'(high_time), mon_m.h);
                check("locked", int'(locked), mon_m.lk);
                check("timeout_at_valid", int'(timeout), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int h;
        int l;
        int r;
        rst    = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high_time), 0);
        check("rst_valid", int'(meas_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_timeout", int'(timeout), 0);
        rst    = 1'b0;
        enable = 1'b1;
        drive(1'b0, 3);

        // Divide-by-4 waveform
        repeat (6) seg(2, 2);
        check("div4_locked", int'(locked), 1);
        check("div4_period", int'(period), 4);

        // Asymmetric, same period different duty, then a new period
        repeat (3) seg(3, 7);
        repeat (3) seg(5, 5);
        repeat (3) seg(4, 4);
        check("relock", int'(locked), 1);

        // Largest legal period, then a one-cycle high pulse
        repeat (3) seg(7, 8);
        check("max_no_timeout", int'(timeout), 0);
        check("max_period", int'(period), 15);
        repeat (2) seg(1, 3);

        // Stuck low after a rise saturates the counter
        model_rise(3, 0);
        drive(1'b1, 3);
        drive(1'b0, 30);
        model_break();
        check("stuck_timeout", int'(timeout), 1);
        check("stuck_locked", int'(locked), 0);
        check("stuck_period_hold", int'(period), last_pub);
        seg(3, 3);
        check("timeout_still_set", int'(timeout), 1);
        seg(3, 3);
        check("timeout_cleared", int'(timeout), 0);
        repeat (3) seg(3, 3);

        // Enable dropped in the low phase of a period
        model_rise(2, 8);
        drive(1'b1, 2);
        drive(1'b0, 2);
        enable = 1'b0;
        drive(1'b0, 2);
        check("gate_locked", int'(locked), 0);
        check("gate_period_hold", int'(period), last_pub);
        check("gate_high_hold", int'(high_time), last_high);
        enable = 1'b1;
        drive(1'b0, 4);
        model_break();
        repeat (3) seg(3, 3);

        // Asynchronous reset in the middle of a measurement
        repeat (3) seg(2, 2);
        model_rise(2, 2);
        drive(1'b1, 2);
        drive(1'b0, 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_high", int'(high_time), 0);
        check("arst_valid", int'(meas_valid), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_timeout", int'(timeout), 0);
        model_break();
        repeat (2) @(posedge clk_in);
        #1;
        rst = 1'b0;
        drive(1'b0, 3);
        repeat (4) seg(2, 2);

        // Random segments, each repeated a few times so lock gets exercised
        repeat (30) begin
            h = int'($urandom_range(1, 6));
            l = int'($urandom_range(1, 7));
            r = int'($urandom_range(1, 3));
            repeat (r) seg(h, l);
        end

        drive(1'b0, 4);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
